// File: rtl/guess_reg_pkg.sv
// Shared definitions for the mastermind guess-entry register: FSM encoding,
// winning-request encoding, default geometry and the count-width helper.
package guess_reg_pkg;

  localparam int PEG_W_DEF = 2;
  localparam int PEGS_DEF  = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Effective action chosen for the current cycle after priority resolution
  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_CLEAR  = 3'd1,
    ACT_COMMIT = 3'd2,
    ACT_UNDO   = 3'd3,
    ACT_ENTER  = 3'd4
  } act_t;

  function automatic int cnt_w(input int pegs);
    return $clog2(pegs + 1);
  endfunction

endpackage

// File: rtl/guess_reg_peg_slot.sv
// One staging slot of the guess register: PEG_W-bit register with
// synchronous clear (dominant) and load, asynchronous active-low reset.
module peg_slot #(
  parameter int PEG_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [PEG_W-1:0] i_d,
  output logic [PEG_W-1:0] o_q
);

  logic [PEG_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_q <= '0;
    else if (i_clr)  r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/guess_reg.sv
// Guess-entry register: stages one peg per enable, commits a full guess to s
// with a one-cycle guess_valid pulse. Optional undo via GUESS_REG_UNDO_EN.
module guess_reg
  import guess_reg_pkg::*;
#(
  parameter int PEG_W = PEG_W_DEF,
  parameter int PEGS  = PEGS_DEF
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [PEG_W-1:0]       a,
  input  logic                   enable,
  input  logic                   commit,
  input  logic                   clear,
`ifdef GUESS_REG_UNDO_EN
  input  logic                   undo,
`endif
  output logic [PEGS*PEG_W-1:0]  s,
  output logic [cnt_w(PEGS)-1:0] count,
  output logic                   full,
  output logic                   guess_valid
);

  localparam int CW = cnt_w(PEGS);

  state_t                r_state;
  state_t                w_state_nxt;
  act_t                  w_act;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic [PEGS*PEG_W-1:0] r_s;
  logic [PEGS*PEG_W-1:0] w_stage;
  logic                  r_valid;
  logic [PEGS-1:0]       w_load;
  logic [PEGS-1:0]       w_clr;

  // Highest-priority asserted request wins even when it is a no-op here
  always_comb begin
    w_act = ACT_NONE;
    if (clear)
      w_act = ACT_CLEAR;
    else if (commit)
      w_act = (r_state == ST_FULL) ? ACT_COMMIT : ACT_NONE;
`ifdef GUESS_REG_UNDO_EN
    else if (undo)
      w_act = (r_state != ST_EMPTY) ? ACT_UNDO : ACT_NONE;
`endif
    else if (enable)
      w_act = (r_state != ST_FULL) ? ACT_ENTER : ACT_NONE;

    w_count_nxt = r_count;
    case (w_act)
      ACT_CLEAR, ACT_COMMIT: w_count_nxt = '0;
      ACT_UNDO:              w_count_nxt = r_count - CW'(1);
      ACT_ENTER:             w_count_nxt = r_count + CW'(1);
      default:               w_count_nxt = r_count;
    endcase

    if (w_count_nxt == '0)              w_state_nxt = ST_EMPTY;
    else if (w_count_nxt == CW'(PEGS))  w_state_nxt = ST_FULL;
    else                                w_state_nxt = ST_FILL;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_count <= '0;
      r_s     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_act == ACT_COMMIT);
      if (w_act == ACT_COMMIT) r_s <= w_stage;
    end
  end

  genvar k;
  generate
    for (k = 0; k < PEGS; k++) begin : g_slot
      assign w_load[k] = (w_act == ACT_ENTER) && (r_count == CW'(k));
      assign w_clr[k]  = (w_act == ACT_CLEAR) || (w_act == ACT_COMMIT) ||
                         ((w_act == ACT_UNDO) && (r_count == CW'(k + 1)));
      peg_slot #(.PEG_W(PEG_W)) u_slot (
        .i_clk   (CLK),
        .i_rst_n (reset),
        .i_load  (w_load[k]),
        .i_clr   (w_clr[k]),
        .i_d     (a),
        .o_q     (w_stage[k*PEG_W +: PEG_W])
      );
    end
  endgenerate

  always_comb begin
    s           = r_s;
    count       = r_count;
    full        = (r_state == ST_FULL);
    guess_valid = r_valid;
  end

endmodule

// File: tb/tb_guess_reg.sv
// Scoreboard bench for guess_reg: driver updates an array-based guess model and
// queues expected status/commits; a monitor compares after every clock edge.
module tb_guess_reg;

  localparam int PEG_W = 2;
  localparam int PEGS  = 4;
  localparam int SW    = PEGS * PEG_W;
`ifdef GUESS_REG_UNDO_EN
  localparam bit UNDO_ON = 1'b1;
`else
  localparam bit UNDO_ON = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic [PEG_W-1:0] a = '0;
  logic             enable = 1'b0;
  logic             commit = 1'b0;
  logic             clear = 1'b0;
`ifdef GUESS_REG_UNDO_EN
  logic             undo = 1'b0;
`endif
  logic [SW-1:0]    s;
  logic [2:0]       count;
  logic             full;
  logic             guess_valid;

  guess_reg #(.PEG_W(PEG_W), .PEGS(PEGS)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .a           (a),
    .enable      (enable),
    .commit      (commit),
    .clear       (clear),
`ifdef GUESS_REG_UNDO_EN
    .undo        (undo),
`endif
    .s           (s),
    .count       (count),
    .full        (full),
    .guess_valid (guess_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            cnt;
    bit            full;
    logic [SW-1:0] s;
    bit            vld;
  } st_t;

  st_t           sq[$];
  logic [SW-1:0] cq[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            mon_en = 1'b0;

  // Reference model: plain array of entered colours plus the committed guess
  int            m_stage[PEGS];
  int            m_cnt = 0;
  logic [SW-1:0] m_s = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] pack_model();
    logic [SW-1:0] v = '0;
    for (int k = 0; k < PEGS; k++) v[k*PEG_W +: PEG_W] = PEG_W'(m_stage[k]);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < PEGS; k++) m_stage[k] = 0;
    m_cnt = 0;
    m_s   = '0;
  endtask

  task automatic drive(input bit en, input int av, input bit cm, input bit cl, input bit ud);
    bit vld = 1'b0;
    @(negedge CLK);
    enable = en;
    a      = PEG_W'(av);
    commit = cm;
    clear  = cl;
`ifdef GUESS_REG_UNDO_EN
    undo   = ud;
`endif
    if (cl) begin
      for (int k = 0; k < PEGS; k++) m_stage[k] = 0;
      m_cnt = 0;
    end else if (cm) begin
      if (m_cnt == PEGS) begin
        m_s = pack_model();
        cq.push_back(m_s);
        vld = 1'b1;
        for (int k = 0; k < PEGS; k++) m_stage[k] = 0;
        m_cnt = 0;
      end
    end else if (ud && UNDO_ON) begin
      if (m_cnt > 0) begin
        m_cnt--;
        m_stage[m_cnt] = 0;
      end
    end else if (en) begin
      if (m_cnt < PEGS) begin
        m_stage[m_cnt] = av;
        m_cnt++;
      end
    end
    sq.push_back('{cnt: m_cnt, full: (m_cnt == PEGS), s: m_s, vld: vld});
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: status every cycle, committed guess whenever guess_valid is seen
  initial begin
    st_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (mon_en && sq.size() > 0) begin
        e = sq.pop_front();
        check("count", 32'(count), 32'(e.cnt));
        check("full", 32'(full), 32'(e.full));
        check("s_stable", 32'(s), 32'(e.s));
        check("guess_valid", 32'(guess_valid), 32'(e.vld));
        if (guess_valid) begin
          if (cq.size() > 0) check("commit_s", 32'(s), 32'(cq.pop_front()));
          else check("unexpected_commit", 32'(guess_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_valid", 32'(guess_valid), 32'd0);
    @(negedge CLK);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Fill 1,2,3,0 then commit -> s = 8'b00_11_10_01
    drive(1, 1, 0, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(1, 3, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    idle();
    check("directed_s", 32'(m_s), 32'h39);

    // Commit while only three pegs entered is ignored
    drive(1, 2, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    // Enable when full is ignored; commit+enable in FULL commits, a discarded
    drive(1, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 2, 0, 0, 0);
    // count=3: clear+commit -> count 0, s untouched, no pulse
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    idle();

`ifdef GUESS_REG_UNDO_EN
    drive(1, 1, 0, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    idle();
`endif

    // Asynchronous reset in the middle of an entry with a non-zero s
    drive(1, 3, 0, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    @(posedge CLK);
    #3;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_full", 32'(full), 32'd0);
    check("async_rst_s", 32'(s), 32'd0);
    check("async_rst_valid", 32'(guess_valid), 32'd0);
    sq.delete();
    cq.delete();
    model_reset();
    enable = 1'b0;
    commit = 1'b0;
    @(negedge CLK);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Randomized traffic biased towards filling and committing
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(99) < 65, int'($urandom_range(3)),
            $urandom_range(99) < 20, $urandom_range(99) < 5,
            $urandom_range(99) < 12);
    end
    idle();
    repeat (3) @(posedge CLK);
    #2;
    check("status_queue_drained", 32'(sq.size()), 32'd0);
    check("commit_queue_drained", 32'(cq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
